// File: rtl/lcd_score_refresh.sv
// Scoreboard LCD text sequencer: HD44780 init, fixed team header, and a live line 2
// (scores or winner banner) that is redrawn whenever the scoring inputs change.
module lcd_score_refresh #(
  parameter int SCORE_W    = 7,
  parameter int DLY_CYCLES = 262143,
  parameter int DLY_W      = 18
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [SCORE_W-1:0] iScore1,
  input  logic [SCORE_W-1:0] iScore2,
  input  logic               iWin1,
  input  logic               iWin2,
  input  logic               iForce,
  output logic [7:0]         oLCD_DATA,
  output logic               oLCD_RS,
  output logic               oLCD_Start,
  input  logic               iLCD_Done,
  output logic               oBusy,
  output logic               oFrameDone
);

  typedef enum logic [2:0] {sStart, sLoad, sWait, sDelay, sNext, sIdle} stateType;

  localparam logic [5:0]       LAST_IDX  = 6'd37;
  localparam logic [5:0]       LINE2_IDX = 6'd21;
  localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'(DLY_CYCLES - 1);

  stateType           state, nextState;
  logic [5:0]         cmdIdx;
  logic [DLY_W-1:0]   dlyCnt;
  logic [SCORE_W-1:0] snapScore1, snapScore2;
  logic               snapWin1, snapWin2;
  logic               forcePending;
  logic [7:0]         lcdData;
  logic               lcdRs, lcdStart;
  logic               liveDiff, forceNow;
  logic [7:0]         cmdData;
  logic               cmdRs;
  logic [3:0]         col;
  logic [7:0]         s1Hi, s1Lo, s2Hi, s2Lo;

  function automatic logic [6:0] satScore(input logic [SCORE_W-1:0] s);
    if (32'(s) > 32'd99) return 7'd99;
    return 7'(s);
  endfunction

  function automatic logic [7:0] tensChar(input logic [6:0] v);
    logic [6:0] t;
    t = v / 7'd10;
    return (t == 7'd0) ? 8'h20 : 8'h30 + {1'b0, t};
  endfunction

  function automatic logic [7:0] onesChar(input logic [6:0] v);
    logic [6:0] o;
    o = v % 7'd10;
    return 8'h30 + {1'b0, o};
  endfunction

  assign liveDiff = {iScore1, iScore2, iWin1, iWin2} !=
                    {snapScore1, snapScore2, snapWin1, snapWin2};
  assign forceNow = iForce || forcePending;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) state <= sStart;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      sStart: nextState = sLoad;
      sLoad:  nextState = sWait;
      sWait:  if (iLCD_Done) nextState = sDelay;
      sDelay: if (dlyCnt == DLY_LAST) nextState = sNext;
      sNext:  nextState = (cmdIdx == LAST_IDX) ? sIdle : sLoad;
      sIdle:  if (forceNow || liveDiff) nextState = sLoad;
      default: nextState = sStart;
    endcase
  end

  always_comb begin
    oBusy      = (state != sIdle);
    oFrameDone = (state == sNext) && (cmdIdx == LAST_IDX);
  end

  // Line 2 is always built from the snapshot so a pass never mixes old and new values.
  always_comb begin
    s1Hi    = tensChar(satScore(snapScore1));
    s1Lo    = onesChar(satScore(snapScore1));
    s2Hi    = tensChar(satScore(snapScore2));
    s2Lo    = onesChar(satScore(snapScore2));
    cmdData = 8'h20;
    cmdRs   = 1'b1;
    col     = 4'd0;
    if (cmdIdx < 6'd5) begin
      cmdRs = 1'b0;
      case (cmdIdx)
        6'd0:    cmdData = 8'h38;
        6'd1:    cmdData = 8'h0C;
        6'd2:    cmdData = 8'h01;
        6'd3:    cmdData = 8'h06;
        default: cmdData = 8'h80;
      endcase
    end else if (cmdIdx < LINE2_IDX) begin
      col = 4'(cmdIdx - 6'd5);
      case (col)
        4'd1, 4'd9:   cmdData = "T";
        4'd2, 4'd10:  cmdData = "e";
        4'd3, 4'd11:  cmdData = "a";
        4'd4, 4'd12:  cmdData = "m";
        4'd5:         cmdData = "1";
        4'd7:         cmdData = "-";
        4'd13:        cmdData = "2";
        default:      cmdData = 8'h20;
      endcase
    end else if (cmdIdx == LINE2_IDX) begin
      cmdRs   = 1'b0;
      cmdData = 8'hC0;
    end else begin
      col = 4'(cmdIdx - 6'd22);
      if (snapWin1 && !snapWin2) begin
        case (col)
          4'd1: cmdData = "W";
          4'd2: cmdData = "i";
          4'd3: cmdData = "n";
          4'd4: cmdData = "n";
          4'd5: cmdData = "e";
          4'd6: cmdData = "r";
          default: cmdData = 8'h20;
        endcase
      end else if (!snapWin1 && snapWin2) begin
        case (col)
          4'd9:  cmdData = "W";
          4'd10: cmdData = "i";
          4'd11: cmdData = "n";
          4'd12: cmdData = "n";
          4'd13: cmdData = "e";
          4'd14: cmdData = "r";
          default: cmdData = 8'h20;
        endcase
      end else begin
        case (col)
          4'd3:  cmdData = s1Hi;
          4'd4:  cmdData = s1Lo;
          4'd7:  cmdData = "-";
          4'd10: cmdData = s2Hi;
          4'd11: cmdData = s2Lo;
          default: cmdData = 8'h20;
        endcase
      end
    end
  end

  // A force seen while busy is remembered and honoured on the first idle cycle.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      cmdIdx       <= 6'd0;
      dlyCnt       <= '0;
      snapScore1   <= '0;
      snapScore2   <= '0;
      snapWin1     <= 1'b0;
      snapWin2     <= 1'b0;
      forcePending <= 1'b0;
      lcdData      <= 8'h00;
      lcdRs        <= 1'b0;
      lcdStart     <= 1'b0;
    end else begin
      if (iForce && state != sIdle) forcePending <= 1'b1;
      case (state)
        sStart: begin
          {snapScore1, snapScore2, snapWin1, snapWin2} <= {iScore1, iScore2, iWin1, iWin2};
          cmdIdx <= 6'd0;
        end
        sLoad: begin
          lcdData  <= cmdData;
          lcdRs    <= cmdRs;
          lcdStart <= 1'b1;
        end
        sWait: if (iLCD_Done) lcdStart <= 1'b0;
        sDelay: begin
          if (dlyCnt == DLY_LAST) dlyCnt <= '0;
          else                    dlyCnt <= dlyCnt + 1'b1;
        end
        sNext: if (cmdIdx != LAST_IDX) cmdIdx <= cmdIdx + 6'd1;
        sIdle: begin
          if (forceNow) begin
            {snapScore1, snapScore2, snapWin1, snapWin2} <= {iScore1, iScore2, iWin1, iWin2};
            cmdIdx       <= 6'd0;
            forcePending <= 1'b0;
          end else if (liveDiff) begin
            {snapScore1, snapScore2, snapWin1, snapWin2} <= {iScore1, iScore2, iWin1, iWin2};
            cmdIdx <= LINE2_IDX;
          end
        end
        default: ;
      endcase
    end
  end

  assign oLCD_DATA  = lcdData;
  assign oLCD_RS    = lcdRs;
  assign oLCD_Start = lcdStart;

endmodule

// File: tb/tb_lcd_score_refresh.sv
// Bench for lcd_score_refresh: LCD controller stand-in plus a text-level model of
// the expected command stream for each frame or refresh pass.
module tb_lcd_score_refresh;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [6:0] iScore1 = '0, iScore2 = '0;
  logic       iWin1 = 1'b0, iWin2 = 1'b0, iForce = 1'b0;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS, oLCD_Start, oBusy, oFrameDone;
  logic       iLCD_Done = 1'b0;

  int checks = 0;
  int errors = 0;
  int frameCount = 0;
  int doneTimer = 0;
  logic prevStart = 1'b0;
  logic [8:0] seen[$];
  logic [8:0] expQ[$];

  lcd_score_refresh #(.SCORE_W(7), .DLY_CYCLES(4), .DLY_W(3)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iScore1(iScore1), .iScore2(iScore2), .iWin1(iWin1), .iWin2(iWin2),
    .iForce(iForce),
    .oLCD_DATA(oLCD_DATA), .oLCD_RS(oLCD_RS), .oLCD_Start(oLCD_Start),
    .iLCD_Done(iLCD_Done), .oBusy(oBusy), .oFrameDone(oFrameDone)
  );

  always #5 iCLK = ~iCLK;

  // Controller stand-in answers each Start with Done three cycles later; also logs commands.
  always @(negedge iCLK) begin
    logic rise;
    rise = oLCD_Start && !prevStart;
    if (rise) seen.push_back({oLCD_RS, oLCD_DATA});
    prevStart = oLCD_Start;
    if (oFrameDone) frameCount++;
    iLCD_Done = 1'b0;
    if (!iRST_N) doneTimer = 0;
    else if (doneTimer > 0) begin
      doneTimer--;
      if (doneTimer == 0) iLCD_Done = 1'b1;
    end else if (rise) doneTimer = 3;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic string twoDigits(input int s);
    int v;
    v = (s > 99) ? 99 : s;
    return (v < 10) ? $sformatf(" %0d", v) : $sformatf("%0d", v);
  endfunction

  task automatic buildExpected(input bit full, input int s1, input int s2, input bit w1, input bit w2);
    string line1, line2;
    line1 = " Team1 - Team2  ";
    if (w1 && !w2)      line2 = " Winner         ";
    else if (!w1 && w2) line2 = "         Winner ";
    else line2 = {"   ", twoDigits(s1), "  -  ", twoDigits(s2), "    "};
    expQ.delete();
    if (full) begin
      expQ.push_back(9'h038); expQ.push_back(9'h00C); expQ.push_back(9'h001);
      expQ.push_back(9'h006); expQ.push_back(9'h080);
      for (int i = 0; i < 16; i++) expQ.push_back({1'b1, line1[i]});
    end
    expQ.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) expQ.push_back({1'b1, line2[i]});
  endtask

  task automatic checkPass(input string name, input bit full, input int s1, input int s2,
                           input bit w1, input bit w2);
    int startFrames, n;
    logic [31:0] got;
    startFrames = frameCount;
    n = 0;
    while (frameCount == startFrames && n < 3000) begin
      @(negedge iCLK);
      n++;
    end
    checkOutput({name, " frameDone"}, 32'(frameCount - startFrames), 32'd1);
    buildExpected(full, s1, s2, w1, w2);
    checkOutput({name, " cmdCount"}, seen.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      got = (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF;
      checkOutput($sformatf("%s cmd%0d", name, i), got, 32'(expQ[i]));
    end
    seen.delete();
  endtask

  task automatic applyStimulus(input int s1, input int s2, input bit w1, input bit w2);
    @(negedge iCLK);
    iScore1 = 7'(s1);
    iScore2 = 7'(s2);
    iWin1   = w1;
    iWin2   = w2;
  endtask

  task automatic pulseForce();
    @(negedge iCLK);
    iForce = 1'b1;
    @(negedge iCLK);
    iForce = 1'b0;
  endtask

  initial begin
    int s1, s2, w;
    int n;
    int tblS1[6] = '{99, 100, 127, 9, 10, 0};
    int tblS2[6] = '{122, 99, 10, 100, 9, 0};
    int tblW[6]  = '{0, 3, 0, 2, 0, 1};

    repeat (3) @(negedge iCLK);
    checkOutput("resetStart", oLCD_Start, 0);
    checkOutput("resetData", oLCD_DATA, 0);
    checkOutput("resetRs", oLCD_RS, 0);
    checkOutput("resetBusy", oBusy, 1);
    checkOutput("resetFrameDone", oFrameDone, 0);
    iRST_N = 1'b1;
    checkPass("initFrame", 1, 0, 0, 0, 0);
    repeat (2) @(negedge iCLK);
    checkOutput("idleBusy", oBusy, 0);

    applyStimulus(15, 0, 0, 0);
    @(negedge iCLK);
    checkOutput("busyAfterChange", oBusy, 1);
    checkPass("score15", 0, 15, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      repeat (2) @(negedge iCLK);
      applyStimulus(tblS1[i], tblS2[i], tblW[i][1], tblW[i][0]);
      checkPass($sformatf("table%0d", i), 0, tblS1[i], tblS2[i], tblW[i][1], tblW[i][0]);
    end

    for (int i = 0; i < 8; i++) begin
      do begin
        s1 = $urandom_range(0, 127);
        s2 = $urandom_range(0, 127);
        w  = $urandom_range(0, 3);
      end while (s1 == int'(iScore1) && s2 == int'(iScore2) && w == int'({iWin1, iWin2}));
      repeat (2) @(negedge iCLK);
      applyStimulus(s1, s2, w[1], w[0]);
      checkPass($sformatf("rand%0d", i), 0, s1, s2, w[1], w[0]);
    end

    repeat (2) @(negedge iCLK);
    applyStimulus(42, 7, 0, 0);
    repeat (30) @(negedge iCLK);
    applyStimulus(42, 7, 1, 0);
    checkPass("oldSnapshot", 0, 42, 7, 0, 0);
    checkPass("winner1", 0, 42, 7, 1, 0);

    repeat (2) @(negedge iCLK);
    applyStimulus(3, 58, 0, 0);
    repeat (20) @(negedge iCLK);
    pulseForce();
    checkPass("refreshBeforeForce", 0, 3, 58, 0, 0);
    checkPass("pendingForce", 1, 3, 58, 0, 0);
    repeat (3) @(negedge iCLK);
    checkOutput("idleBeforeForce", oBusy, 0);
    pulseForce();
    checkPass("idleForce", 1, 3, 58, 0, 0);

    repeat (2) @(negedge iCLK);
    applyStimulus(64, 58, 0, 1);
    n = 0;
    while (!oLCD_Start && n < 100) begin
      @(negedge iCLK);
      n++;
    end
    checkOutput("reachedWait", oLCD_Start, 1);
    iRST_N = 1'b0;
    @(negedge iCLK);
    checkOutput("abortStart", oLCD_Start, 0);
    checkOutput("abortBusy", oBusy, 1);
    checkOutput("abortData", oLCD_DATA, 0);
    repeat (4) @(negedge iCLK);
    seen.delete();
    iRST_N = 1'b1;
    checkPass("afterAbort", 1, 64, 58, 0, 1);
    repeat (2) @(negedge iCLK);
    checkOutput("finalIdle", oBusy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
